rca_accumulator: RTL and testbench

- Frame accumulator that sits around one `ripple_carry_adder_n_bit` instance.
- Feeds the adder's `a` port from its running-sum register and `b` from incoming samples; consumes the adder's `sum`/`cout` each accepted beat.
- Sums COUNT unsigned input samples per frame and emits the frame total plus a sticky overflow flag over a valid/ready handshake.
- Sits between a sample source and any downstream consumer of frame totals.

---
 rtl/rca_pkg.sv | 20 ++
 rtl/ripple_carry_adder_n_bit.sv | 29 ++
 rtl/rca_accumulator.sv | 116 +++++++++++
 tb/tb_rca_accumulator.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/rca_pkg.sv
// Shared definitions for the frame accumulator.
//   state_t    : accumulator FSM encoding (ACCUM collects samples, DONE holds a result)
//   clog2_min1 : bit width needed to count 0..value-1, never less than one bit
package rca_pkg;

  typedef enum logic {
    ACCUM = 1'b0,
    DONE  = 1'b1
  } state_t;

  function automatic int clog2_min1(input int value);
    int w;
    w = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) w = i + 1;
    end
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/ripple_carry_adder_n_bit.sv
// Plain ripple-carry adder: each bit is a full adder whose carry feeds the next.
//   a, b : WIDTH-bit operands
//   cin  : carry into bit 0
//   sum  : a + b + cin modulo 2^WIDTH
//   cout : carry out of the top bit
module ripple_carry_adder_n_bit #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  // The carry is walked bit by bit in a local variable so the chain reads
  // like the textbook full-adder cascade.
  always_comb begin
    logic c;
    sum = '0;
    c   = cin;
    for (int i = 0; i < WIDTH; i++) begin
      sum[i] = a[i] ^ b[i] ^ c;
      c      = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
    end
    cout = c;
  end

endmodule

// File: rtl/rca_accumulator.sv
// Frame accumulator: sums COUNT unsigned samples through a ripple-carry adder
// and presents the frame total with a sticky wrap flag.
//   clk, rst   : rising-edge clock, asynchronous active-high reset
//   clr        : synchronous abort; drops the current frame and any pending result
//   in_data    : WIDTH-bit unsigned sample, qualified by in_valid
//   in_valid / in_ready   : sample handshake
//   out_data   : ACC_WIDTH-bit frame total (modulo 2^ACC_WIDTH)
//   out_ovf    : a carry-out occurred somewhere in the frame
//   out_valid / out_ready : result handshake
//
// Handshakes: a beat transfers on a rising edge where valid and ready are both
// high. in_ready is high only while collecting samples; out_valid is high only
// while a result is held, and the result stays stable until out_ready is seen.
// The two never overlap, so a result must be consumed before the next sample.
module rca_accumulator
  import rca_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter int ACC_WIDTH = 8,
  parameter int COUNT     = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clr,
  input  logic [WIDTH-1:0]     in_data,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [ACC_WIDTH-1:0] out_data,
  output logic                 out_ovf,
  output logic                 out_valid,
  input  logic                 out_ready
);

  localparam int CNT_W = clog2_min1(COUNT);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(COUNT - 1);

  state_t               state;
  state_t               state_next;
  logic [ACC_WIDTH-1:0] acc;
  logic [ACC_WIDTH-1:0] b_ext;
  logic [ACC_WIDTH-1:0] sum;
  logic                 cout;
  logic [CNT_W-1:0]     cnt;
  logic                 ovf;
  logic                 accept;
  logic                 last_beat;

  assign b_ext     = ACC_WIDTH'(in_data);
  assign accept    = in_valid && in_ready;
  assign last_beat = (cnt == LAST);

  ripple_carry_adder_n_bit #(
    .WIDTH(ACC_WIDTH)
  ) u_adder (
    .a   (acc),
    .b   (b_ext),
    .cin (1'b0),
    .sum (sum),
    .cout(cout)
  );

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ACCUM;
    else     state <= state_next;
  end

  // Next-state logic; clr overrides everything
  always_comb begin
    state_next = state;
    if (clr) begin
      state_next = ACCUM;
    end else begin
      case (state)
        ACCUM: if (accept && last_beat) state_next = DONE;
        DONE:  if (out_ready)           state_next = ACCUM;
        default: state_next = ACCUM;
      endcase
    end
  end

  // Handshake outputs follow the state directly
  always_comb begin
    in_ready  = (state == ACCUM);
    out_valid = (state == DONE);
  end

  // Datapath registers. acc only ever loads on an accepted beat, so a sample
  // presented without in_valid never enters the sum.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc      <= '0;
      cnt      <= '0;
      ovf      <= 1'b0;
      out_data <= '0;
      out_ovf  <= 1'b0;
    end else if (clr) begin
      acc <= '0;
      cnt <= '0;
      ovf <= 1'b0;
    end else if (accept) begin
      if (last_beat) begin
        out_data <= sum;
        out_ovf  <= ovf | cout;
        acc      <= '0;
        cnt      <= '0;
        ovf      <= 1'b0;
      end else begin
        acc <= sum;
        ovf <= ovf | cout;
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_rca_accumulator.sv
module tb_rca_accumulator;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic       clr = 1'b0;
  logic [3:0] in_data = '0;
  logic       in_valid = 1'b0;
  logic       out_ready = 1'b1;

  // default-width instance
  logic       in_ready;
  logic [7:0] out_data;
  logic       out_ovf;
  logic       out_valid;

  // narrow-accumulator instance sharing the same stimulus
  logic       in_ready5;
  logic [4:0] out_data5;
  logic       out_ovf5;
  logic       out_valid5;

  rca_accumulator dut (
    .clk(clk), .rst(rst), .clr(clr),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_ovf(out_ovf), .out_valid(out_valid),
    .out_ready(out_ready)
  );

  rca_accumulator #(.WIDTH(4), .ACC_WIDTH(5), .COUNT(4)) dut5 (
    .clk(clk), .rst(rst), .clr(clr),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready5),
    .out_data(out_data5), .out_ovf(out_ovf5), .out_valid(out_valid5),
    .out_ready(out_ready)
  );

  // scoreboard
  logic [7:0] exp_q[$];
  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // driver: present one beat, let one edge pass, sample 1ns later
  task automatic send(input logic [3:0] v, input logic valid);
    in_valid = valid;
    in_data  = valid ? v : 4'bxxxx;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // checks a result on the default instance against the scoreboard head
  task automatic check_result(input string tag);
    logic [7:0] e;
    if (exp_q.size() == 0) begin
      check({tag, "_queue_empty"}, 32'd1, 32'd0);
    end else begin
      e = exp_q.pop_front();
      check({tag, "_valid"}, out_valid, 1);
      check({tag, "_data"}, out_data, e);
      check({tag, "_in_ready"}, in_ready, 0);
    end
  endtask

  initial begin
    // reset
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", out_valid, 0);
    check("rst_data", out_data, 0);
    check("rst_ovf", out_ovf, 0);
    rst = 1'b0;
    #1;
    check("rst_in_ready", in_ready, 1);

    // T1: 1,2,3,4 -> 10
    exp_q.push_back(8'd10);
    send(4'd1, 1); send(4'd2, 1); send(4'd3, 1);
    check("t1_mid_valid", out_valid, 0);
    send(4'd4, 1);
    check_result("t1");
    check("t1_ovf", out_ovf, 0);
    idle(1);
    check("t1_drop_valid", out_valid, 0);
    check("t1_in_ready", in_ready, 1);

    // T2: 15 x4 with out_ready low for 5 cycles -> 60 held
    out_ready = 1'b0;
    exp_q.push_back(8'd60);
    for (int i = 0; i < 4; i++) send(4'd15, 1);
    check_result("t2");
    for (int i = 0; i < 5; i++) begin
      // keep offering a sample; it must not be taken while a result is held
      send(4'd7, 1);
      check("t2_hold_valid", out_valid, 1);
      check("t2_hold_data", out_data, 60);
      check("t2_hold_ready", in_ready, 0);
    end
    out_ready = 1'b1;
    idle(1);
    check("t2_release_valid", out_valid, 0);
    check("t2_release_ready", in_ready, 1);

    // T3: 15 x4 -> default 60/0, 5-bit 28/1; then 1 x4 -> 4/0 on both
    exp_q.push_back(8'd60);
    for (int i = 0; i < 4; i++) send(4'd15, 1);
    check_result("t3a");
    check("t3a_ovf", out_ovf, 0);
    check("t3a_w5_valid", out_valid5, 1);
    check("t3a_w5_data", out_data5, 28);
    check("t3a_w5_ovf", out_ovf5, 1);
    idle(1);
    exp_q.push_back(8'd4);
    for (int i = 0; i < 4; i++) send(4'd1, 1);
    check_result("t3b");
    check("t3b_w5_data", out_data5, 4);
    check("t3b_w5_ovf", out_ovf5, 0);
    idle(1);

    // T4: 5,6 then clr with sample 7 -> dropped; 1 x4 -> 4
    send(4'd5, 1); send(4'd6, 1);
    clr = 1'b1;
    send(4'd7, 1);
    clr = 1'b0;
    check("t4_clr_valid", out_valid, 0);
    check("t4_clr_ready", in_ready, 1);
    exp_q.push_back(8'd4);
    for (int i = 0; i < 4; i++) send(4'd1, 1);
    check_result("t4");

    // clr while a result is pending discards it
    out_ready = 1'b0;
    idle(1);
    check("t4_pending_valid", out_valid, 1);
    clr = 1'b1;
    idle(1);
    clr = 1'b0;
    out_ready = 1'b1;
    check("t4_discard_valid", out_valid, 0);
    check("t4_discard_ready", in_ready, 1);

    // T5: gapped valid 1,0,0,1,1,0,1 with 2,x,x,3,4,x,5 -> 14 after last
    exp_q.push_back(8'd14);
    send(4'd2, 1); send(4'd0, 0); send(4'd0, 0);
    send(4'd3, 1); send(4'd4, 1); send(4'd0, 0);
    check("t5_early_valid", out_valid, 0);
    send(4'd5, 1);
    check_result("t5");
    idle(1);

    // T6: async reset mid-frame after 9,9
    send(4'd9, 1); send(4'd9, 1);
    #2 rst = 1'b1;
    #1;
    check("t6_rst_valid", out_valid, 0);
    check("t6_rst_data", out_data, 0);
    check("t6_rst_ovf", out_ovf, 0);
    check("t6_rst_w5_data", out_data5, 0);
    #1 rst = 1'b0;
    @(posedge clk); #1;
    check("t6_ready", in_ready, 1);
    exp_q.push_back(8'd10);
    send(4'd1, 1); send(4'd2, 1); send(4'd3, 1); send(4'd4, 1);
    check_result("t6");
    check("t6_w5_data", out_data5, 10);
    idle(1);

    check("final_queue_empty", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
